// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the register-file access sequencer.
// The out-of-range helper is the single definition of which indices reach the register file.
package reg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_RSP  = 2'd2
  } seq_state_t;

  localparam int NUM_REGS = 16;
  localparam int SP_IDX   = 14;
  localparam int RA_IDX   = 15;

  function automatic logic addr_oor(input int unsigned addr);
    return addr >= NUM_REGS;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry writeback FIFO.
// Exposes every slot with its valid bit and the youngest slot index so the reader can forward pending writes.
module wb_fifo
  import reg_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int WB_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push_i,
  input  logic [ADDR_W-1:0]                push_addr_i,
  input  logic [DATA_W-1:0]                push_data_i,
  input  logic                             pop_i,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [ADDR_W-1:0]                head_addr_o,
  output logic [DATA_W-1:0]                head_data_o,
  output logic [WB_DEPTH-1:0][ADDR_W-1:0]  ent_addr_o,
  output logic [WB_DEPTH-1:0][DATA_W-1:0]  ent_data_o,
  output logic [WB_DEPTH-1:0]              ent_vld_o,
  output logic                             young_o
);

  logic [WB_DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [WB_DEPTH-1:0][DATA_W-1:0] data_q;
  logic                            wr_ptr_q, rd_ptr_q;
  logic [1:0]                      cnt_q;
  logic                            push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'(WB_DEPTH));
  assign empty_o = (cnt_q == 2'd0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      data_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        addr_q[wr_ptr_q] <= push_addr_i;
        data_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign ent_addr_o  = addr_q;
  assign ent_data_o  = data_q;
  // The most recent push landed one slot behind the write pointer.
  assign young_o     = ~wr_ptr_q;

  always_comb begin
    ent_vld_o    = '0;
    ent_vld_o[0] = full_o || ((cnt_q == 2'd1) && (rd_ptr_q == 1'b0));
    ent_vld_o[1] = full_o || ((cnt_q == 2'd1) && (rd_ptr_q == 1'b1));
  end

endmodule

// File: rtl/reg_access_sequencer.sv
// Initiator side of the register-file port: operand reads with writeback forwarding,
// buffered writebacks drained to the register file except while read addresses are presented.
module reg_access_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int WB_DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_rsp_valid,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wb_req_valid,
  output logic              wb_req_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_err,
  output logic [ADDR_W-1:0] Read_Reg1,
  output logic [ADDR_W-1:0] Read_Reg2,
  input  logic [DATA_W-1:0] Read_Data1,
  input  logic [DATA_W-1:0] Read_Data2,
  output logic [ADDR_W-1:0] Write_Reg,
  output logic [DATA_W-1:0] Write_Data,
  output logic              RegWrite,
  output logic              busy
);

  seq_state_t state_q, state_d;
  logic [ADDR_W-1:0] raddr1_q, raddr2_q;
  logic [DATA_W-1:0] rdata1_q, rdata2_q;
  logic [DATA_W-1:0] fwd1, fwd2;
  logic              rd_accept, push, pop, full, empty, head_oor;
  logic              young, older;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [WB_DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [WB_DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [WB_DEPTH-1:0]             ent_vld;

  assign rd_req_ready = (state_q == IDLE);
  assign rd_accept    = rd_req_valid && rd_req_ready;
  assign wb_req_ready = !full;
  assign push         = wb_req_valid && !full;
  // Draining is held off while read addresses are on the port so captured operands are never torn.
  assign pop          = !empty && (state_q != RD_ADDR);
  assign head_oor     = addr_oor(32'(head_addr));

  wb_fifo #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .WB_DEPTH(WB_DEPTH)
  ) u_wb_fifo (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .push_i     (push),
    .push_addr_i(wb_addr),
    .push_data_i(wb_data),
    .pop_i      (pop),
    .full_o     (full),
    .empty_o    (empty),
    .head_addr_o(head_addr),
    .head_data_o(head_data),
    .ent_addr_o (ent_addr),
    .ent_data_o (ent_data),
    .ent_vld_o  (ent_vld),
    .young_o    (young)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_accept) state_d = RD_ADDR;
      RD_ADDR: state_d = RD_RSP;
      RD_RSP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign older = ~young;

  // Youngest matching pending write wins over older entries and the register file.
  always_comb begin
    fwd1 = Read_Data1;
    if (ent_vld[older] && (ent_addr[older] == raddr1_q)) fwd1 = ent_data[older];
    if (ent_vld[young] && (ent_addr[young] == raddr1_q)) fwd1 = ent_data[young];
    if (addr_oor(32'(raddr1_q))) fwd1 = '0;
    fwd2 = Read_Data2;
    if (ent_vld[older] && (ent_addr[older] == raddr2_q)) fwd2 = ent_data[older];
    if (ent_vld[young] && (ent_addr[young] == raddr2_q)) fwd2 = ent_data[young];
    if (addr_oor(32'(raddr2_q))) fwd2 = '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      raddr1_q <= '0;
      raddr2_q <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_accept) begin
        raddr1_q <= rd_addr1;
        raddr2_q <= rd_addr2;
      end
      if (state_q == RD_ADDR) begin
        rdata1_q <= fwd1;
        rdata2_q <= fwd2;
      end
    end
  end

  assign Read_Reg1    = raddr1_q;
  assign Read_Reg2    = raddr2_q;
  assign rd_data1     = rdata1_q;
  assign rd_data2     = rdata2_q;
  assign rd_rsp_valid = (state_q == RD_RSP);
  assign RegWrite     = pop && !head_oor;
  assign wb_err       = pop && head_oor;
  assign Write_Reg    = RegWrite ? head_addr : '0;
  assign Write_Data   = RegWrite ? head_data : '0;
  assign busy         = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Directed self-checking bench for reg_access_sequencer with a behavioural 16-entry register file.
module tb_reg_access_sequencer;

  logic        Clk, Reset_n;
  logic        rd_req_valid, rd_req_ready, rd_rsp_valid;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        wb_req_valid, wb_req_ready, wb_err;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  Read_Reg1, Read_Reg2, Write_Reg;
  logic [31:0] Read_Data1, Read_Data2, Write_Data;
  logic        RegWrite, busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] regs [16];
  logic        rf_init_done = 1'b0;

  reg_access_sequencer #(.DATA_W(32), .ADDR_W(5), .WB_DEPTH(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_rsp_valid(rd_rsp_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_err(wb_err),
    .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2),
    .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
    .Write_Reg(Write_Reg), .Write_Data(Write_Data), .RegWrite(RegWrite),
    .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file: combinational read, write at the end of the RegWrite cycle.
  assign Read_Data1 = regs[Read_Reg1[3:0]];
  assign Read_Data2 = regs[Read_Reg2[3:0]];
  always @(posedge Clk) begin
    if (!rf_init_done) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'(i * 17);
      regs[7] <= 32'h700;
      rf_init_done <= 1'b1;
    end else if (RegWrite) begin
      regs[Write_Reg[3:0]] <= Write_Data;
    end
  end

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  task automatic idle_inputs();
    rd_req_valid = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
    wb_req_valid = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) begin
      rd_req_valid = 1'($urandom); rd_addr1 = 5'($urandom); rd_addr2 = 5'($urandom);
      wb_req_valid = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
      cyc();
      checks++;
      if ({rd_rsp_valid, wb_err, RegWrite, busy} !== 4'b0) begin
        errors++; $display("FAIL reset_flags: got %b expected 0000", {rd_rsp_valid, wb_err, RegWrite, busy});
      end
      checks++;
      if ({rd_data1, rd_data2, Write_Data} !== 96'h0) begin
        errors++; $display("FAIL reset_data: got %h %h %h expected zeros", rd_data1, rd_data2, Write_Data);
      end
      checks++;
      if ({Read_Reg1, Read_Reg2, Write_Reg} !== 15'h0) begin
        errors++; $display("FAIL reset_addr: got %h %h %h expected zeros", Read_Reg1, Read_Reg2, Write_Reg);
      end
      checks++;
      if ({rd_req_ready, wb_req_ready} !== 2'b11) begin
        errors++; $display("FAIL reset_ready: got %b expected 11", {rd_req_ready, wb_req_ready});
      end
    end
    idle_inputs();
    @(negedge Clk) Reset_n = 1'b1;
    cyc();
    checks++;
    if ({rd_req_ready, wb_req_ready, busy} !== 3'b110) begin
      errors++; $display("FAIL post_reset: got %b expected 110", {rd_req_ready, wb_req_ready, busy});
    end
  endtask

  task automatic test_first_read();
    rd_req_valid = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd4;
    cyc();
    rd_req_valid = 1'b0;
    checks++;
    if ({rd_rsp_valid, rd_req_ready, Read_Reg1, Read_Reg2} !== {1'b0, 1'b0, 5'd3, 5'd4}) begin
      errors++; $display("FAIL read_addr_cycle: got v=%b r=%b %0d %0d expected v=0 r=0 3 4",
                         rd_rsp_valid, rd_req_ready, Read_Reg1, Read_Reg2);
    end
    cyc();
    checks++;
    if ({rd_rsp_valid, rd_data1, rd_data2} !== {1'b1, 32'h33, 32'h44}) begin
      errors++; $display("FAIL read_rsp: got v=%b %h %h expected v=1 33 44", rd_rsp_valid, rd_data1, rd_data2);
    end
    cyc();
    checks++;
    if ({rd_rsp_valid, rd_req_ready, rd_data1} !== {1'b0, 1'b1, 32'h33}) begin
      errors++; $display("FAIL read_after: got v=%b r=%b %h expected v=0 r=1 33", rd_rsp_valid, rd_req_ready, rd_data1);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_rsp, exp_rdy;
    exp_rsp = 6'b010010;
    exp_rdy = 6'b001001;
    rd_req_valid = 1'b1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++;
      if ({rd_rsp_valid, rd_req_ready} !== {exp_rsp[5-i], exp_rdy[5-i]}) begin
        errors++; $display("FAIL b2b_cycle%0d: got v=%b r=%b expected v=%b r=%b",
                           i, rd_rsp_valid, rd_req_ready, exp_rsp[5-i], exp_rdy[5-i]);
      end
    end
    rd_req_valid = 1'b0;
    checks++;
    if (rd_data1 !== 32'h11 || rd_data2 !== 32'h22) begin
      errors++; $display("FAIL b2b_data: got %h %h expected 11 22", rd_data1, rd_data2);
    end
    cyc();
  endtask

  task automatic test_forward_and_block();
    wb_req_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hA;
    cyc();
    checks++;
    if ({RegWrite, Write_Reg, Write_Data} !== {1'b1, 5'd5, 32'hA}) begin
      errors++; $display("FAIL wb_latency: got we=%b %0d %h expected we=1 5 a", RegWrite, Write_Reg, Write_Data);
    end
    wb_data = 32'hB;
    rd_req_valid = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd4;
    cyc();
    rd_req_valid = 1'b0;
    wb_addr = 5'd6; wb_data = 32'h66;
    checks++;
    if ({RegWrite, wb_req_ready, Read_Reg1} !== {1'b0, 1'b1, 5'd5}) begin
      errors++; $display("FAIL block_rd_addr: got we=%b rdy=%b rr1=%0d expected we=0 rdy=1 rr1=5",
                         RegWrite, wb_req_ready, Read_Reg1);
    end
    checks++;
    if (regs[5] !== 32'hA) begin
      errors++; $display("FAIL rf_r5_first: got %h expected a", regs[5]);
    end
    cyc();
    wb_req_valid = 1'b0;
    checks++;
    if ({rd_rsp_valid, rd_data1, rd_data2} !== {1'b1, 32'hB, 32'h44}) begin
      errors++; $display("FAIL forward_young: got v=%b %h %h expected v=1 b 44", rd_rsp_valid, rd_data1, rd_data2);
    end
    checks++;
    if ({wb_req_ready, RegWrite, Write_Reg, Write_Data} !== {1'b0, 1'b1, 5'd5, 32'hB}) begin
      errors++; $display("FAIL drain_rsp: got rdy=%b we=%b %0d %h expected rdy=0 we=1 5 b",
                         wb_req_ready, RegWrite, Write_Reg, Write_Data);
    end
    cyc();
    checks++;
    if ({wb_req_ready, RegWrite, Write_Reg, Write_Data} !== {1'b1, 1'b1, 5'd6, 32'h66}) begin
      errors++; $display("FAIL drain_idle: got rdy=%b we=%b %0d %h expected rdy=1 we=1 6 66",
                         wb_req_ready, RegWrite, Write_Reg, Write_Data);
    end
    cyc();
    checks++;
    if ({busy, regs[5], regs[6]} !== {1'b0, 32'hB, 32'h66}) begin
      errors++; $display("FAIL final_rf: got busy=%b r5=%h r6=%h expected busy=0 r5=b r6=66", busy, regs[5], regs[6]);
    end
  endtask

  task automatic test_out_of_range();
    wb_req_valid = 1'b1; wb_addr = 5'h12; wb_data = 32'h1234;
    cyc();
    wb_req_valid = 1'b0;
    checks++;
    if ({wb_err, RegWrite} !== 2'b10) begin
      errors++; $display("FAIL oor_pop: got err=%b we=%b expected err=1 we=0", wb_err, RegWrite);
    end
    cyc();
    checks++;
    if ({wb_err, busy, regs[2]} !== {1'b0, 1'b0, 32'h22}) begin
      errors++; $display("FAIL oor_after: got err=%b busy=%b r2=%h expected err=0 busy=0 r2=22", wb_err, busy, regs[2]);
    end
    rd_req_valid = 1'b1; rd_addr1 = 5'h1F; rd_addr2 = 5'd3;
    cyc();
    rd_req_valid = 1'b0;
    cyc();
    checks++;
    if ({rd_rsp_valid, rd_data1, rd_data2} !== {1'b1, 32'h0, 32'h33}) begin
      errors++; $display("FAIL oor_read: got v=%b %h %h expected v=1 0 33", rd_rsp_valid, rd_data1, rd_data2);
    end
    cyc();
  endtask

  task automatic test_collision();
    rd_req_valid = 1'b1; rd_addr1 = 5'd7; rd_addr2 = 5'd3;
    wb_req_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    cyc();
    idle_inputs();
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++; $display("FAIL collide_block: got we=%b expected 0", RegWrite);
    end
    cyc();
    checks++;
    if ({rd_rsp_valid, rd_data1, RegWrite, Write_Reg} !== {1'b1, 32'h77, 1'b1, 5'd7}) begin
      errors++; $display("FAIL collide_fwd: got v=%b %h we=%b wr=%0d expected v=1 77 we=1 wr=7",
                         rd_rsp_valid, rd_data1, RegWrite, Write_Reg);
    end
    cyc();
  endtask

  task automatic test_reset_mid_read();
    rd_req_valid = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd4;
    wb_req_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h9999;
    cyc();
    idle_inputs();
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, rd_req_ready, RegWrite, Read_Reg1} !== {1'b0, 1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL mid_reset_async: got busy=%b rdy=%b we=%b rr1=%0d expected 0 1 0 0",
                         busy, rd_req_ready, RegWrite, Read_Reg1);
    end
    cyc();
    checks++;
    if (rd_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_rsp: got %b expected 0", rd_rsp_valid);
    end
    @(negedge Clk) Reset_n = 1'b1;
    cyc();
    checks++;
    if ({rd_rsp_valid, RegWrite, busy} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_after: got v=%b we=%b busy=%b expected 000", rd_rsp_valid, RegWrite, busy);
    end
    cyc();
    checks++;
    if (regs[9] !== 32'h99) begin
      errors++; $display("FAIL mid_reset_discard: got r9=%h expected 99", regs[9]);
    end
  endtask

  initial begin
    idle_inputs();
    Reset_n = 1'b0;
    test_reset();
    test_first_read();
    test_back_to_back();
    test_forward_and_block();
    test_out_of_range();
    test_collision();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
